// File: rtl/bram_log_ctrl.sv
// Capture/readout sequencer for one simple dual-port block RAM with a 2-cycle registered read.
// Optional LOG_WRAP_EN turns the one-shot capture into a circular log that runs until stop.
module bram_log_ctrl #(
  parameter int RAM_EXP   = 15,
  parameter int RAM_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [RAM_WIDTH-1:0] i_data_log,
  input  logic                 i_data_valid,
  input  logic                 i_read_req,
  input  logic [RAM_EXP-1:0]   i_read_addr,
  output logic [RAM_WIDTH-1:0] o_read_data,
  output logic                 o_read_valid,
  output logic                 o_busy,
  output logic                 o_full,
  output logic [RAM_EXP:0]     o_count,
  output logic [RAM_EXP-1:0]   o_addr_w,
  output logic [RAM_EXP-1:0]   o_addr_r,
  output logic [RAM_WIDTH-1:0] o_data_ram,
  output logic                 o_write_enb,
  output logic                 o_read_enb,
  output logic                 o_out_enb,
  output logic                 o_out_rst,
  input  logic [RAM_WIDTH-1:0] i_data_ram
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [RAM_EXP:0] COUNT_MAX = {1'b1, {RAM_EXP{1'b0}}};

  state_t                 state, state_nxt;
  logic [RAM_EXP-1:0]     wr_ptr;
  logic                   start_go, write_go, wrap_point, last_write, read_go;
  logic                   read_valid_q;
  logic [RAM_WIDTH-1:0]   read_hold;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    start_go   = i_start && (state != CAPTURE);
    write_go   = (state == CAPTURE) && i_data_valid;
    wrap_point = write_go && (wr_ptr == '1);
`ifdef LOG_WRAP_EN
    last_write = 1'b0;
`else
    last_write = wrap_point;
`endif
    // Start has priority over a read, and only one read may be in the RAM pipeline at a time.
    read_go = i_read_req && (state != CAPTURE) && !i_start && !o_read_enb && !o_out_enb;

    state_nxt = state;
    case (state)
      IDLE:    if (start_go) state_nxt = CAPTURE;
      CAPTURE: if (i_stop || last_write) state_nxt = DONE;
      DONE:    if (start_go) state_nxt = CAPTURE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      o_count      <= '0;
      o_full       <= 1'b0;
      o_addr_w     <= '0;
      o_data_ram   <= '0;
      o_write_enb  <= 1'b0;
      o_out_rst    <= 1'b0;
      o_addr_r     <= '0;
      o_read_enb   <= 1'b0;
      o_out_enb    <= 1'b0;
      read_valid_q <= 1'b0;
      read_hold    <= '0;
    end else begin
      o_out_rst   <= start_go;
      o_write_enb <= write_go;

      if (start_go) begin
        wr_ptr  <= '0;
        o_count <= '0;
        o_full  <= 1'b0;
      end else if (write_go) begin
        o_addr_w   <= wr_ptr;
        o_data_ram <= i_data_log;
        wr_ptr     <= wr_ptr + 1'b1;
        if (o_count != COUNT_MAX) o_count <= o_count + 1'b1;
        if (wrap_point)           o_full  <= 1'b1;
      end

      // A start kills whichever read stage is in flight so no stale valid escapes.
      o_read_enb   <= read_go;
      o_out_enb    <= o_read_enb && !start_go;
      read_valid_q <= o_out_enb && !start_go;
      if (read_go)      o_addr_r  <= i_read_addr;
      if (read_valid_q) read_hold <= i_data_ram;
    end
  end

  assign o_busy       = (state == CAPTURE);
  assign o_read_valid = read_valid_q;
  assign o_read_data  = read_valid_q ? i_data_ram : read_hold;

endmodule

// File: tb/tb_bram_log_ctrl.sv
// Bench for bram_log_ctrl (RAM_EXP=3) with a behavioural 2-cycle RAM and a read scoreboard.
module tb_bram_log_ctrl;

  localparam int EXP = 3;
  localparam int W   = 32;
`ifdef LOG_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           i_rst, i_start, i_stop, i_data_valid, i_read_req;
  logic [W-1:0]   i_data_log;
  logic [EXP-1:0] i_read_addr;
  logic [W-1:0]   o_read_data, o_data_ram, i_data_ram;
  logic           o_read_valid, o_busy, o_full, o_write_enb, o_read_enb, o_out_enb, o_out_rst;
  logic [EXP:0]   o_count;
  logic [EXP-1:0] o_addr_w, o_addr_r;

  bram_log_ctrl #(.RAM_EXP(EXP), .RAM_WIDTH(W)) dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_data_log(i_data_log), .i_data_valid(i_data_valid),
    .i_read_req(i_read_req), .i_read_addr(i_read_addr),
    .o_read_data(o_read_data), .o_read_valid(o_read_valid),
    .o_busy(o_busy), .o_full(o_full), .o_count(o_count),
    .o_addr_w(o_addr_w), .o_addr_r(o_addr_r), .o_data_ram(o_data_ram),
    .o_write_enb(o_write_enb), .o_read_enb(o_read_enb), .o_out_enb(o_out_enb),
    .o_out_rst(o_out_rst), .i_data_ram(i_data_ram)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: read latch on read_enb, output register on out_enb; contents ignore i_rst.
  logic [W-1:0] mem [0:(1<<EXP)-1];
  logic [W-1:0] rd_lat, out_reg;
  initial begin
    for (int i = 0; i < (1 << EXP); i++) mem[i] = '0;
    rd_lat  = '0;
    out_reg = '0;
  end
  always @(posedge clk) begin
    if (o_write_enb) mem[o_addr_w] <= o_data_ram;
    if (o_read_enb)  rd_lat <= mem[o_addr_r];
    if (o_out_rst)      out_reg <= '0;
    else if (o_out_enb) out_reg <= rd_lat;
  end
  assign i_data_ram = out_reg;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every read strobe must match the oldest expected read, on its due cycle.
  always @(negedge clk) begin
    if (o_read_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_read_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("read_data", o_read_data, e.data);
        check("read_latency", cyc, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input logic [EXP-1:0] addr, input logic [W-1:0] exp);
    exp_t e;
    i_read_req  = 1'b1;
    i_read_addr = addr;
    e.data = exp;
    e.due  = cyc + 3;
    sb.push_back(e);
    step();
    i_read_req = 1'b0;
    check("rd_read_enb", o_read_enb, 1);
    check("rd_addr_r", o_addr_r, addr);
    step();
    check("rd_out_enb", o_out_enb, 1);
    step();
    step();
    check("rd_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("start_out_rst", o_out_rst, 1);
    check("start_busy", o_busy, 1);
    check("start_count", o_count, 0);
  endtask

  task automatic stop_pulse();
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_data_valid = 1'b0;
    i_read_req = 1'b0; i_data_log = '0; i_read_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_data", o_read_data, 0);
    check("rst_read_valid", o_read_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_full", o_full, 0);
    check("rst_count", o_count, 0);
    check("rst_addr_w", o_addr_w, 0);
    check("rst_addr_r", o_addr_r, 0);
    check("rst_data_ram", o_data_ram, 0);
    check("rst_write_enb", o_write_enb, 0);
    check("rst_read_enb", o_read_enb, 0);
    check("rst_out_enb", o_out_enb, 0);
    check("rst_out_rst", o_out_rst, 0);
    i_rst = 1'b0;
    step();
    check("idle_busy", o_busy, 0);
    read_word(0, 32'h0);

    // Short capture of five samples then stop.
    start_pulse();
    for (int k = 0; k < 5; k++) begin
      i_data_valid = 1'b1;
      i_data_log   = 32'h11 + k;
      step();
      check("cap_write_enb", o_write_enb, 1);
      check("cap_addr_w", o_addr_w, k);
      check("cap_data_ram", o_data_ram, 32'h11 + k);
    end
    i_data_valid = 1'b0;
    stop_pulse();
    check("cap5_busy", o_busy, 0);
    check("cap5_count", o_count, 5);
    check("cap5_full", o_full, 0);
    read_word(3, 32'h14);
    read_word(0, 32'h11);

    // Ten back-to-back samples into an eight-word buffer.
    start_pulse();
    for (int k = 1; k <= 10; k++) begin
      i_data_valid = 1'b1;
      i_data_log   = 32'hA0 + k;
      step();
      if (k == 8) begin
        check("fill8_busy", o_busy, WRAP);
        check("fill8_full", o_full, 1);
        check("fill8_count", o_count, 8);
      end
      if (k == 9) check("fill9_write_enb", o_write_enb, WRAP);
    end
    i_data_valid = 1'b0;
    stop_pulse();
    check("fill_busy", o_busy, 0);
    check("fill_full", o_full, 1);
    check("fill_count", o_count, 8);
    if (WRAP) begin
      read_word(0, 32'hA9);
      read_word(1, 32'hAA);
      read_word(2, 32'hA3);
    end else begin
      read_word(0, 32'hA1);
      read_word(1, 32'hA2);
      read_word(7, 32'hA8);
    end

    // Read request while capturing is dropped; stop together with a sample still writes it.
    start_pulse();
    i_read_req  = 1'b1;
    i_read_addr = 2;
    step();
    i_read_req = 1'b0;
    check("cap_read_enb_a", o_read_enb, 0);
    step();
    check("cap_read_enb_b", o_read_enb, 0);
    i_data_valid = 1'b1;
    i_data_log   = 32'h55;
    i_stop       = 1'b1;
    step();
    i_data_valid = 1'b0;
    i_stop       = 1'b0;
    check("stopv_busy", o_busy, 0);
    check("stopv_count", o_count, 1);
    check("stopv_write_enb", o_write_enb, 1);
    read_word(0, 32'h55);

    // Start and read together in DONE: start wins.
    i_start     = 1'b1;
    i_read_req  = 1'b1;
    i_read_addr = 0;
    step();
    i_start    = 1'b0;
    i_read_req = 1'b0;
    check("startrd_busy", o_busy, 1);
    check("startrd_read_enb_a", o_read_enb, 0);
    step();
    check("startrd_read_enb_b", o_read_enb, 0);
    stop_pulse();
    check("startrd_stop_busy", o_busy, 0);
    check("startrd_count", o_count, 0);

    // Asynchronous reset in the middle of a read: no valid may follow.
    i_read_req  = 1'b1;
    i_read_addr = 0;
    step();
    i_read_req = 1'b0;
    check("rstrd_read_enb", o_read_enb, 1);
    step();
    check("rstrd_out_enb", o_out_enb, 1);
    i_rst = 1'b1;
    #1;
    check("rstrd_out_enb_cleared", o_out_enb, 0);
    check("rstrd_addr_r", o_addr_r, 0);
    step();
    step();
    i_rst = 1'b0;
    repeat (4) step();
    check("rstrd_busy", o_busy, 0);
    check("rstrd_read_valid", o_read_valid, 0);
    read_word(0, 32'h55);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_log_ctrl.md
# bram_log_ctrl

Capture/readout sequencer for the simple dual-port block RAM in the register file. It fills the RAM with a burst of modulator samples on a start command, then serves single-word host reads. Read timing matches the RAM's 2-cycle HIGH_PERFORMANCE read latency. It sits between the modulator datapath or register-file host logic and one RAM instance, and owns all of that RAM's control ports.

## Interface
- RAM_EXP, 15, RAM address width; depth D = 2**RAM_EXP
- RAM_WIDTH, 32, data word width
- clk  in  1  single clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  pulse: begin capture
- i_stop  in  1  pulse: end capture
- i_data_log  in  RAM_WIDTH  sample to store
- i_data_valid  in  1  sample strobe
- i_read_req  in  1  pulse: read one word
- i_read_addr  in  RAM_EXP  read address, sampled with i_read_req
- o_read_data  out  RAM_WIDTH  read result
- o_read_valid  out  1  one-cycle strobe qualifying o_read_data
- o_busy  out  1  capture in progress
- o_full  out  1  buffer filled
- o_count  out  RAM_EXP+1  words captured, saturating at D
- o_addr_w, o_addr_r  out  RAM_EXP  to RAM
- o_data_ram  out  RAM_WIDTH  to RAM write data
- o_write_enb, o_read_enb, o_out_enb, o_out_rst  out  1  to RAM
- i_data_ram  in  RAM_WIDTH  RAM output register

## Operation
- Reset: state IDLE; all outputs 0; write pointer 0; read pipeline empty.
- States: IDLE, CAPTURE, DONE.
- IDLE/DONE + i_start -> CAPTURE.
  - Clear write pointer, o_count, o_full.
  - Pulse o_out_rst for 1 cycle.
  - Abort any in-flight read; no o_read_valid is produced for it.
- CAPTURE + i_data_valid: write i_data_log at write pointer.
  - o_write_enb, o_addr_w, o_data_ram are registered (RAM write lands 1 cycle after the strobe).
  - Pointer +1; o_count +1.
- CAPTURE + i_stop -> DONE. If i_data_valid is set the same cycle, that sample is still written.
- CAPTURE, write of address D-1: o_full=1, o_count=D, -> DONE. Further valids are dropped. (LOG_WRAP_EN changes this; see Configuration.)
- i_start during CAPTURE: ignored. i_stop outside CAPTURE: ignored.
- i_read_req is accepted only in IDLE/DONE with no read in flight; otherwise dropped.
- i_start and i_read_req in the same cycle: start wins, read dropped.
- o_busy = (state == CAPTURE).

## Timing
- Read request sampled at cycle N:
  - N+1: o_read_enb=1, o_addr_r=addr.
  - N+2: o_out_enb=1.
  - N+3: o_read_valid=1, o_read_data = i_data_ram (combinational pass-through). o_read_data holds its value until the next valid.
- Read latency is 3 cycles; at most one read in flight. A new request is accepted from cycle N+3 onward.
- o_read_enb and o_out_enb are single-cycle pulses; both are 0 otherwise.
- Capture throughput: 1 word/cycle. Last-write to DONE: same edge as the write is registered.
- Asynchronous reset mid-capture or mid-read: immediate return to IDLE with reset values. RAM contents are untouched.

## Configuration
- LOG_WRAP_EN defined:
  - Write pointer wraps D-1 -> 0 and capture continues until i_stop.
  - o_full sets on the first wrap and stays set.
  - o_count saturates at D.
  - On i_stop, the oldest sample is at the current write pointer.
- LOG_WRAP_EN undefined: capture stops at D words as described in Operation; no wrap logic is built.

## Test plan
- Reset then idle: all outputs 0; i_read_req at addr 0 -> o_read_valid exactly 3 cycles later, data 0.
- Start, 5 valids with data 0x11..0x15, stop -> DONE, o_count=5, o_full=0; reading addr 3 returns 0x14 with 3-cycle latency.
- RAM_EXP=3, start, 10 consecutive valids, no LOG_WRAP_EN:
  - DONE after the 8th write, o_full=1, o_count=8.
  - Samples 9-10 are not written; addr 0 still holds the first sample.
- Same stimulus with LOG_WRAP_EN, then stop:
  - addr 0 = sample 9, addr 1 = sample 10, addr 2 = sample 3.
  - o_count=8, o_full=1.
- Boundary collisions:
  - read request during CAPTURE -> no o_read_enb.
  - i_stop with i_data_valid -> sample written.
  - i_start with i_read_req in DONE -> capture starts, no read.
  - i_rst asserted mid-read -> no o_read_valid.
